// File: rtl/bomberman_pkg.sv
// rtl/bomberman_pkg.sv - shared FSM encoding and screen constants for the field renderer
// Purpose: state encoding, default tile/sprite codes and clip bounds shared by
// the renderer and its pixel counter.
// Ports: none (package).
package bomberman_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    TILE,
    PLAYER,
    DONE
  } state_t;

  localparam logic [3:0] SKIP_CODE_DEF   = 4'hF;
  localparam logic [3:0] PLAYER_BASE_DEF = 4'h8;
  localparam int         SCREEN_W_DEF    = 320;
  localparam int         SCREEN_H_DEF    = 240;

  // Width at which pixel coordinates are formed before clipping, so that
  // sprites hanging off the right/bottom edge do not wrap back on screen.
  localparam int COORD_W = 10;

endpackage

// File: rtl/sprite_pixel_counter.sv
// rtl/sprite_pixel_counter.sv - col/row stepper for one square tile or sprite
// Purpose: walks the pixels of one 2^TILE_LOG2 square, col fastest then row.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   clear        : synchronous return to pixel (0,0)
//   step         : advance one pixel
//   col, row     : current pixel inside the sprite
//   last         : current pixel is the bottom-right one
//   wrap         : stepping off the last pixel this cycle (sprite finished)
module sprite_pixel_counter #(
  parameter int TILE_LOG2 = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 step,
  output logic [TILE_LOG2-1:0] col,
  output logic [TILE_LOG2-1:0] row,
  output logic                 last,
  output logic                 wrap
);

  assign last = (&col) & (&row);
  assign wrap = step & last;

  // Both fields roll over naturally, so a finished sprite leaves the counter
  // at (0,0) ready for the next one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (step) begin
      col <= col + 1'b1;
      if (&col) begin
        row <= row + 1'b1;
      end
    end
  end

endmodule

// File: rtl/field_renderer.sv
// rtl/field_renderer.sv - renders the tile grid then the player sprites as a pixel stream
// Purpose: per frame, fetches each tile code from stage memory, emits one pixel
// per tile pixel, then emits the enabled player sprites, clipping off-screen pixels.
// Ports:
//   clock, reset           : rising-edge clock, asynchronous active-high reset
//   start                  : frame request pulse (ignored while busy)
//   busy, frame_done       : frame in progress / one-cycle end-of-frame pulse
//   tile_addr, tile_data   : stage memory address, code returned one cycle later
//   player_x/_y/_en        : flattened player positions (player 0 in LSBs), enables
//   pix_x, pix_y           : screen coordinate of the offered pixel
//   sprite_idx, sprite_off : sprite to sample and {row,col} inside it
//   pix_valid, pix_ready   : pixel handshake; transfer when both high
module field_renderer
  import bomberman_pkg::*;
#(
  parameter int         GRID_W      = 11,
  parameter int         GRID_H      = 11,
  parameter int         TILE_LOG2   = 4,
  parameter int         NUM_PLAYERS = 2,
  parameter int         ORIGIN_X    = 72,
  parameter int         ORIGIN_Y    = 32,
  parameter int         SCREEN_W    = SCREEN_W_DEF,
  parameter int         SCREEN_H    = SCREEN_H_DEF,
  parameter logic [3:0] SKIP_CODE   = SKIP_CODE_DEF,
  parameter logic [3:0] PLAYER_BASE = PLAYER_BASE_DEF,
  localparam int        AW          = $clog2(GRID_W * GRID_H)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     frame_done,
  output logic [AW-1:0]            tile_addr,
  input  logic [3:0]               tile_data,
  input  logic [9*NUM_PLAYERS-1:0] player_x,
  input  logic [8*NUM_PLAYERS-1:0] player_y,
  input  logic [NUM_PLAYERS-1:0]   player_en,
  output logic [8:0]               pix_x,
  output logic [7:0]               pix_y,
  output logic [3:0]               sprite_idx,
  output logic [2*TILE_LOG2-1:0]   sprite_off,
  output logic                     pix_valid,
  input  logic                     pix_ready
);

  localparam int TXW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int TYW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int PW  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  state_t               state, state_n;
  logic [TXW-1:0]       tx, tx_n;
  logic [TYW-1:0]       ty, ty_n;
  logic [PW-1:0]        pidx, pidx_n;
  logic                 loaded, loaded_n;
  logic [3:0]           idx_n;
  logic [COORD_W-1:0]   base_x, base_x_n;
  logic [COORD_W-1:0]   base_y, base_y_n;
  logic [TILE_LOG2-1:0] col, row;
  logic                 last, wrap, step, act, in_bounds;
  logic                 adv_tile, next_player;
  logic [COORD_W-1:0]   cur_x, cur_y;
  logic [8:0]           sel_x;
  logic [7:0]           sel_y;

  sprite_pixel_counter #(
    .TILE_LOG2(TILE_LOG2)
  ) u_counter (
    .clock(clock),
    .reset(reset),
    .clear(state == IDLE),
    .step (step),
    .col  (col),
    .row  (row),
    .last (last),
    .wrap (wrap)
  );

  assign sel_x = player_x[int'(pidx) * 9 +: 9];
  assign sel_y = player_y[int'(pidx) * 8 +: 8];

  assign cur_x     = base_x + COORD_W'(col);
  assign cur_y     = base_y + COORD_W'(row);
  assign in_bounds = (cur_x < COORD_W'(SCREEN_W)) && (cur_y < COORD_W'(SCREEN_H));

  // A player slot spends its first PLAYER cycle sampling position/enable;
  // only a loaded slot produces pixels.
  assign act  = (state == TILE) || ((state == PLAYER) && loaded);
  // Clipped pixels still consume one cycle each, without a handshake.
  assign step = act && (pix_ready || !in_bounds);

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign pix_valid  = act && in_bounds;
  assign pix_x      = act ? cur_x[8:0] : '0;
  assign pix_y      = act ? cur_y[7:0] : '0;
  assign sprite_off = act ? {row, col} : '0;
  assign tile_addr  = (state == FETCH) ? AW'(int'(ty) * GRID_W + int'(tx)) : '0;

  always_comb begin
    state_n     = state;
    tx_n        = tx;
    ty_n        = ty;
    pidx_n      = pidx;
    loaded_n    = loaded;
    idx_n       = sprite_idx;
    base_x_n    = base_x;
    base_y_n    = base_y;
    adv_tile    = 1'b0;
    next_player = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          tx_n    = '0;
          ty_n    = '0;
        end
      end
      FETCH: state_n = WAIT;
      WAIT: begin
        idx_n = tile_data;
        if (tile_data != SKIP_CODE) begin
          state_n  = TILE;
          base_x_n = COORD_W'(ORIGIN_X) + (COORD_W'(tx) << TILE_LOG2);
          base_y_n = COORD_W'(ORIGIN_Y) + (COORD_W'(ty) << TILE_LOG2);
        end else begin
          adv_tile = 1'b1;
        end
      end
      TILE: adv_tile = wrap;
      PLAYER: begin
        if (!loaded) begin
          if (player_en[pidx]) begin
            loaded_n = 1'b1;
            base_x_n = COORD_W'(sel_x);
            base_y_n = COORD_W'(sel_y);
            idx_n    = PLAYER_BASE + 4'(pidx);
          end else begin
            next_player = 1'b1;
          end
        end else begin
          next_player = wrap;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (adv_tile) begin
      if (tx == TXW'(GRID_W - 1)) begin
        tx_n = '0;
        if (ty == TYW'(GRID_H - 1)) begin
          ty_n     = '0;
          state_n  = PLAYER;
          pidx_n   = '0;
          loaded_n = 1'b0;
        end else begin
          ty_n    = ty + 1'b1;
          state_n = FETCH;
        end
      end else begin
        tx_n    = tx + 1'b1;
        state_n = FETCH;
      end
    end

    if (next_player) begin
      loaded_n = 1'b0;
      if (pidx == PW'(NUM_PLAYERS - 1)) begin
        state_n = DONE;
      end else begin
        pidx_n = pidx + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= '0;
      ty         <= '0;
      pidx       <= '0;
      loaded     <= 1'b0;
      sprite_idx <= '0;
      base_x     <= '0;
      base_y     <= '0;
    end else begin
      state      <= state_n;
      tx         <= tx_n;
      ty         <= ty_n;
      pidx       <= pidx_n;
      loaded     <= loaded_n;
      sprite_idx <= idx_n;
      base_x     <= base_x_n;
      base_y     <= base_y_n;
    end
  end

endmodule
